// File: rtl/rom_pic_overlay_if.sv
// ROM read bus between the overlay engine and an external single-port image ROM.
//   rom_addr : word address, driven by the overlay (master)
//   rom_data : packed {R,G,B} read data, driven by the ROM (slave), valid a fixed
//              number of clocks after rom_addr
interface rom_pic_overlay_if #(
    parameter int unsigned COLOR_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0]    rom_addr;
    logic [3*COLOR_DEPTH-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/rom_pic_overlay.sv
// Picture-overlay engine: tracks video timing, fetches a stored image from an external
// ROM inside a movable window and merges it into the background stream (RGB, grey,
// threshold or invert). Total latency from input sample to output is RD_LAT + 2 clocks.
// Ports:
//   clk, rst_n               pixel clock, asynchronous active-low reset
//   en, mode, pos_x, pos_y,
//   thresh                   overlay controls, captured at frame start (vs_in rise)
//   vs_in, hs_in, de_in,
//   rgb_in                   incoming timing and background pixel {R,G,B}
//   rom                      ROM read bus (address out, data in)
//   vs_out, hs_out, de_out,
//   rgb_out                  delayed timing and merged pixel
module rom_pic_overlay #(
    parameter int unsigned COLOR_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned IMG_W       = 256,
    parameter int unsigned IMG_H       = 256,
    parameter int unsigned H_BITS      = 12,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [H_BITS-1:0]        pos_x,
    input  logic [H_BITS-1:0]        pos_y,
    input  logic [COLOR_DEPTH-1:0]   thresh,
    input  logic                     vs_in,
    input  logic                     hs_in,
    input  logic                     de_in,
    input  logic [3*COLOR_DEPTH-1:0] rgb_in,
    rom_pic_overlay_if.master        rom,
    output logic                     vs_out,
    output logic                     hs_out,
    output logic                     de_out,
    output logic [3*COLOR_DEPTH-1:0] rgb_out
);
    localparam int unsigned PixW   = 3 * COLOR_DEPTH;
    localparam int unsigned Lat    = RD_LAT + 2;
    localparam int unsigned HitDly = RD_LAT + 1;  // address register plus ROM latency
    localparam int unsigned LumaW  = COLOR_DEPTH + 8;

    typedef enum logic [1:0] {
        ModeRgb    = 2'b00,
        ModeGrey   = 2'b01,
        ModeThresh = 2'b10,
        ModeInvert = 2'b11
    } mode_e;

    // Timing tracking and frame-latched controls
    logic                   vs_q, de_q;
    logic [H_BITS-1:0]      x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d, rom_addr_q, rom_addr_d;
    logic                   en_s_q, en_s_d;
    mode_e                  mode_s_q, mode_s_d;
    logic [H_BITS-1:0]      pos_x_s_q, pos_x_s_d, pos_y_s_q, pos_y_s_d;
    logic [COLOR_DEPTH-1:0] thresh_s_q, thresh_s_d;

    // Delay lines
    logic [2:0]             sync_q [Lat];
    logic [2:0]             sync_d [Lat];
    logic [PixW-1:0]        bg_q [Lat-1];
    logic [PixW-1:0]        bg_d [Lat-1];
    logic [HitDly-1:0]      hit_q, hit_d;
    mode_e                  mode_p_q [HitDly];
    mode_e                  mode_p_d [HitDly];
    logic [COLOR_DEPTH-1:0] thr_p_q [HitDly];
    logic [COLOR_DEPTH-1:0] thr_p_d [HitDly];
    logic [PixW-1:0]        rgb_out_q, rgb_out_d;

    logic                   frame_start, de_fall, in_x, in_y, hit;
    logic [H_BITS:0]        dx, dy;
    logic [COLOR_DEPTH-1:0] rom_r, rom_g, rom_b, luma;
    logic [LumaW-1:0]       luma_sum;

    always_comb begin
        frame_start = vs_in & ~vs_q;
        de_fall     = de_q & ~de_in;

        // A borrow (bit H_BITS set) means the pixel is left of / above the window.
        dx   = {1'b0, x_cnt_q} - {1'b0, pos_x_s_q};
        dy   = {1'b0, y_cnt_q} - {1'b0, pos_y_s_q};
        in_x = ~dx[H_BITS] && (32'(dx) < IMG_W);
        in_y = ~dy[H_BITS] && (32'(dy) < IMG_H);
        hit  = en_s_q & de_in & in_x & in_y;

        x_cnt_d = de_in ? x_cnt_q + 1'b1 : '0;

        // Frame-start clearing takes priority over a coincident de falling edge.
        y_cnt_d    = y_cnt_q;
        row_base_d = row_base_q;
        if (frame_start) begin
            y_cnt_d    = '0;
            row_base_d = '0;
        end else if (de_fall) begin
            y_cnt_d = y_cnt_q + 1'b1;
            if (in_y) row_base_d = row_base_q + ADDR_WIDTH'(IMG_W);
        end

        rom_addr_d = hit ? row_base_q + ADDR_WIDTH'(dx) : rom_addr_q;

        en_s_d     = en_s_q;
        mode_s_d   = mode_s_q;
        pos_x_s_d  = pos_x_s_q;
        pos_y_s_d  = pos_y_s_q;
        thresh_s_d = thresh_s_q;
        if (frame_start) begin
            en_s_d     = en;
            mode_s_d   = mode_e'(mode);
            pos_x_s_d  = pos_x;
            pos_y_s_d  = pos_y;
            thresh_s_d = thresh;
        end
    end

    always_comb begin
        sync_d[0] = {vs_in, hs_in, de_in};
        for (int unsigned i = 1; i < Lat; i++) sync_d[i] = sync_q[i-1];
        bg_d[0] = rgb_in;
        for (int unsigned i = 1; i < Lat - 1; i++) bg_d[i] = bg_q[i-1];
        hit_d       = {hit_q[HitDly-2:0], hit};
        mode_p_d[0] = mode_s_q;
        thr_p_d[0]  = thresh_s_q;
        for (int unsigned i = 1; i < HitDly; i++) begin
            mode_p_d[i] = mode_p_q[i-1];
            thr_p_d[i]  = thr_p_q[i-1];
        end
    end

    // Merge stage: rom_data lines up with the last hit/mode/thresh stage.
    always_comb begin
        rom_r    = rom.rom_data[PixW-1 -: COLOR_DEPTH];
        rom_g    = rom.rom_data[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
        rom_b    = rom.rom_data[COLOR_DEPTH-1:0];
        luma_sum = LumaW'(77) * LumaW'(rom_r) + LumaW'(150) * LumaW'(rom_g)
                 + LumaW'(29) * LumaW'(rom_b);
        luma     = luma_sum[LumaW-1 -: COLOR_DEPTH];

        rgb_out_d = bg_q[Lat-2];
        if (hit_q[HitDly-1]) begin
            unique case (mode_p_q[HitDly-1])
                ModeRgb:    rgb_out_d = rom.rom_data;
                ModeGrey:   rgb_out_d = {3{luma}};
                ModeThresh: rgb_out_d = (luma >= thr_p_q[HitDly-1]) ? {PixW{1'b1}}
                                                                     : {PixW{1'b0}};
                ModeInvert: rgb_out_d = ~rom.rom_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            row_base_q <= '0;
            rom_addr_q <= '0;
            en_s_q     <= 1'b0;
            mode_s_q   <= ModeRgb;
            pos_x_s_q  <= '0;
            pos_y_s_q  <= '0;
            thresh_s_q <= '0;
            sync_q     <= '{default: '0};
            bg_q       <= '{default: '0};
            hit_q      <= '0;
            mode_p_q   <= '{default: ModeRgb};
            thr_p_q    <= '{default: '0};
            rgb_out_q  <= '0;
        end else begin
            vs_q       <= vs_in;
            de_q       <= de_in;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            row_base_q <= row_base_d;
            rom_addr_q <= rom_addr_d;
            en_s_q     <= en_s_d;
            mode_s_q   <= mode_s_d;
            pos_x_s_q  <= pos_x_s_d;
            pos_y_s_q  <= pos_y_s_d;
            thresh_s_q <= thresh_s_d;
            sync_q     <= sync_d;
            bg_q       <= bg_d;
            hit_q      <= hit_d;
            mode_p_q   <= mode_p_d;
            thr_p_q    <= thr_p_d;
            rgb_out_q  <= rgb_out_d;
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign vs_out       = sync_q[Lat-1][2];
    assign hs_out       = sync_q[Lat-1][1];
    assign de_out       = sync_q[Lat-1][0];
    assign rgb_out      = rgb_out_q;
endmodule

// File: tb/tb_rom_pic_overlay.sv
// Bench for rom_pic_overlay: two instances (ROM latency 1 and 2) driven in parallel and
// compared against a window/pixel reference model working on frame coordinates.
module tb_rom_pic_overlay;
    localparam int unsigned CD = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned IH = 4;
    localparam int unsigned HB = 12;
    localparam int ACT_W = 8;
    localparam int ACT_H = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [HB-1:0] pos_x = '0;
    logic [HB-1:0] pos_y = '0;
    logic [CD-1:0] thresh = '0;
    logic          vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic [23:0]   rgb_in = '0;
    logic          vs1, hs1, de1, vs2, hs2, de2;
    logic [23:0]   rgb1, rgb2;

    rom_pic_overlay_if #(.COLOR_DEPTH(CD), .ADDR_WIDTH(AW)) bus1 ();
    rom_pic_overlay_if #(.COLOR_DEPTH(CD), .ADDR_WIDTH(AW)) bus2 ();

    rom_pic_overlay #(
        .COLOR_DEPTH(CD), .ADDR_WIDTH(AW), .IMG_W(IW), .IMG_H(IH), .H_BITS(HB), .RD_LAT(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pos_x(pos_x), .pos_y(pos_y),
        .thresh(thresh), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .rgb_in(rgb_in),
        .rom(bus1), .vs_out(vs1), .hs_out(hs1), .de_out(de1), .rgb_out(rgb1)
    );

    rom_pic_overlay #(
        .COLOR_DEPTH(CD), .ADDR_WIDTH(AW), .IMG_W(IW), .IMG_H(IH), .H_BITS(HB), .RD_LAT(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pos_x(pos_x), .pos_y(pos_y),
        .thresh(thresh), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .rgb_in(rgb_in),
        .rom(bus2), .vs_out(vs2), .hs_out(hs2), .de_out(de2), .rgb_out(rgb2)
    );

    always #5 clk = ~clk;

    // Image ROM shared by both instances, with 1 and 2 clocks of read latency.
    logic [23:0] rom_mem [16];
    logic [23:0] r1_q = '0;
    logic [23:0] r2_q0 = '0, r2_q1 = '0;
    always @(posedge clk) begin
        r1_q  <= rom_mem[bus1.rom_addr[3:0]];
        r2_q0 <= rom_mem[bus2.rom_addr[3:0]];
        r2_q1 <= r2_q0;
    end
    assign bus1.rom_data = r1_q;
    assign bus2.rom_data = r2_q1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [26:0] hist [$];      // expected {vs,hs,de,rgb} per sampled clock
    int          exp_addr = 0;
    bit          prev_vs = 1'b0;
    bit          sh_en = 1'b0;
    logic [1:0]  sh_mode = 2'd0;
    int          sh_px = 0, sh_py = 0;
    logic [7:0]  sh_th = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [23:0] ref_pix(input logic [23:0] w, input logic [1:0] m,
                                            input logic [7:0] th);
        int y;
        logic [7:0] y8;
        y  = (77 * int'(w[23:16]) + 150 * int'(w[15:8]) + 29 * int'(w[7:0])) / 256;
        y8 = 8'(y);
        case (m)
            2'd0:    return w;
            2'd1:    return {y8, y8, y8};
            2'd2:    return (y8 >= th) ? 24'hFFFFFF : 24'h000000;
            default: return ~w;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_addr1"}, 32'(bus1.rom_addr), 32'd0);
        chk({tag, "_addr2"}, 32'(bus2.rom_addr), 32'd0);
        chk({tag, "_out1"}, 32'({vs1, hs1, de1, rgb1}), 32'd0);
        chk({tag, "_out2"}, 32'({vs2, hs2, de2, rgb2}), 32'd0);
    endtask

    task automatic reset_cycles(input int k);
        rst_n = 1'b0;
        {vs_in, hs_in, de_in, rgb_in} = '0;
        sh_en = 1'b0; sh_mode = 2'd0; sh_px = 0; sh_py = 0; sh_th = '0;
        prev_vs = 1'b0; exp_addr = 0;
        for (int i = 0; i < k; i++) begin
            hist.push_back('0);
            @(posedge clk); #1;
            check_zero("in_reset");
        end
        rst_n = 1'b1;
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        reset_cycles(4);
    endtask

    // One sampled clock: predict, drive, clock, compare.
    task automatic step(input logic vs, input logic hs, input logic de, input logic [23:0] pix,
                        input int x, input int y);
        int ax, ay, n;
        logic [23:0] e_rgb;
        ax = x - sh_px;
        ay = y - sh_py;
        e_rgb = pix;
        if (sh_en && de && ax >= 0 && ax < int'(IW) && ay >= 0 && ay < int'(IH)) begin
            exp_addr = ay * int'(IW) + ax;
            e_rgb = ref_pix(rom_mem[exp_addr], sh_mode, sh_th);
        end
        if (vs && !prev_vs) begin
            sh_en = en; sh_mode = mode; sh_px = int'(pos_x); sh_py = int'(pos_y); sh_th = thresh;
        end
        prev_vs = vs;
        hist.push_back({vs, hs, de, e_rgb});
        vs_in = vs; hs_in = hs; de_in = de; rgb_in = pix;
        @(posedge clk); #1;
        n = hist.size() - 1;
        chk("rom_addr_lat1", 32'(bus1.rom_addr), 32'(exp_addr));
        chk("rom_addr_lat2", 32'(bus2.rom_addr), 32'(exp_addr));
        if (n >= 2) chk("out_lat3", 32'({vs1, hs1, de1, rgb1}), 32'(hist[n-2]));
        if (n >= 3) chk("out_lat4", 32'({vs2, hs2, de2, rgb2}), 32'(hist[n-3]));
    endtask

    task automatic run_frame(input bit ramp, input int chg_line, input int rst_line);
        for (int i = 0; i < 6; i++) step(i < 3, 1'b0, 1'b0, 24'($urandom), 0, 0);
        for (int ln = 0; ln < ACT_H; ln++) begin
            if (ln == chg_line) begin
                en = 1'($urandom); mode = 2'($urandom); thresh = 8'($urandom);
                pos_x = HB'($urandom_range(0, ACT_W)); pos_y = HB'($urandom_range(0, ACT_H));
            end
            for (int px = 0; px < ACT_W; px++) begin
                if (ln == rst_line && px == 3) mid_reset();
                step(1'b0, 1'b0, 1'b1, ramp ? 24'(ln * ACT_W + px) : 24'($urandom), px, ln);
            end
            for (int h = 0; h < 4; h++) step(1'b0, h < 2, 1'b0, 24'($urandom), 0, 0);
        end
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
    endtask

    task automatic rom_index();
        for (int a = 0; a < 16; a++) rom_mem[a] = 24'(a);
    endtask

    task automatic rom_random();
        for (int a = 0; a < 16; a++) rom_mem[a] = 24'($urandom);
    endtask

    task automatic set_ctl(input bit e, input logic [1:0] m, input int px, input int py,
                           input logic [7:0] th);
        en = e; mode = m; pos_x = HB'(px); pos_y = HB'(py); thresh = th;
    endtask

    initial begin
        rom_random();
        reset_cycles(4);

        // Pass-through: 64-pixel ramp with overlay disabled
        set_ctl(1'b0, 2'd0, 0, 0, 8'h00);
        run_frame(1'b1, -1, -1);

        // RGB window at (2,1), ROM[a] = a
        rom_index();
        set_ctl(1'b1, 2'd0, 2, 1, 8'h00);
        run_frame(1'b0, -1, -1);

        // Grey
        rom_random();
        rom_mem[0] = 24'hFF0000; rom_mem[1] = 24'hFFFFFF;
        set_ctl(1'b1, 2'd1, 0, 0, 8'h00);
        run_frame(1'b0, -1, -1);

        // Threshold at 0x80 with Y exactly 0x80 and 0x7F
        rom_mem[0] = 24'h808080; rom_mem[1] = 24'h7F7F7F;
        set_ctl(1'b1, 2'd2, 0, 0, 8'h80);
        run_frame(1'b0, -1, -1);

        // Invert
        rom_mem[0] = 24'h123456;
        set_ctl(1'b1, 2'd3, 1, 2, 8'h80);
        run_frame(1'b0, -1, -1);

        // Clipped at right and bottom edges
        rom_index();
        set_ctl(1'b1, 2'd0, ACT_W - 2, ACT_H - 2, 8'h00);
        run_frame(1'b0, -1, -1);

        // Window entirely off screen
        set_ctl(1'b1, 2'd0, ACT_W, 0, 8'h00);
        run_frame(1'b0, -1, -1);

        // Controls changed mid-frame must not take effect until the next frame
        set_ctl(1'b1, 2'd0, 3, 2, 8'h40);
        run_frame(1'b0, 3, -1);
        set_ctl(1'b1, 2'd3, 0, 1, 8'h40);
        run_frame(1'b0, -1, -1);

        // Reset in the middle of a windowed line, then recovery on the next frame
        rom_random();
        set_ctl(1'b1, 2'd0, 0, 0, 8'h00);
        run_frame(1'b0, -1, 2);
        run_frame(1'b0, -1, -1);

        // Randomised frames
        for (int f = 0; f < 8; f++) begin
            rom_random();
            set_ctl($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, ACT_W + 1),
                    $urandom_range(0, ACT_H + 1), 8'($urandom));
            run_frame(1'b0, (f % 2 == 0) ? $urandom_range(1, ACT_H - 1) : -1, -1);
        end

        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_pic_overlay.md
# rom_pic_overlay

Pipelined picture-overlay engine for the HDMI demo path. It tracks the incoming video timing, computes the address of a stored image held in an external single-port ROM, and merges the ROM pixel into the background stream inside a movable window. Four pixel modes are supported: RGB, grey, binary threshold and invert. It sits between the video timing/pattern source and the HDMI encoder, and generalises the fixed 24-bit image ROM used in the grey-picture demo.

## Interface
- COLOR_DEPTH, 8, bits per colour channel; pixel width is 3*COLOR_DEPTH, packed {R,G,B}
- ADDR_WIDTH, 16, ROM address width
- IMG_W, 256, stored image width in pixels
- IMG_H, 256, stored image height in pixels; IMG_W*IMG_H ≤ 2^ADDR_WIDTH
- H_BITS, 12, width of the x/y position counters
- RD_LAT, 1, ROM read latency in clocks (≥1)

Ports:
- clk  in  1  pixel clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset
- en  in  1  overlay enable, sampled at frame start
- mode  in  2  00 RGB, 01 grey, 10 threshold, 11 invert; sampled at frame start
- pos_x, pos_y  in  H_BITS  top-left window corner in active pixels; sampled at frame start
- thresh  in  COLOR_DEPTH  binarisation level; sampled at frame start
- vs_in, hs_in, de_in  in  1  input sync and data enable
- rgb_in  in  3*COLOR_DEPTH  background pixel
- rom_addr  out  ADDR_WIDTH  ROM address
- rom_data  in  3*COLOR_DEPTH  ROM read data, valid RD_LAT clocks after rom_addr
- vs_out, hs_out, de_out  out  1  delayed syncs
- rgb_out  out  3*COLOR_DEPTH  merged pixel

## Operation
- Frame start is the rising edge of vs_in, detected against a registered copy. At frame start, en, mode, pos_x, pos_y and thresh are captured into shadow registers; y_cnt=0; row_base=0. Changes mid-frame have no effect.
- x_cnt increments on each de_in=1 clock and clears on the first clock after de_in falls. y_cnt increments on each de_in falling edge.
- hit = en_s & de_in & (x_cnt−pos_x_s) < IMG_W & (y_cnt−pos_y_s) < IMG_H. Both subtractions are unsigned at H_BITS+1 bits, with the borrow treated as a miss. A window clipped by the screen edge is therefore handled correctly.
- rom_addr = row_base + (x_cnt−pos_x_s), truncated to ADDR_WIDTH, registered. rom_addr holds its value when hit=0.
- row_base += IMG_W on each de_in falling edge of a line in which y was inside the window.
- Merge stage, applied when the delayed hit=1, with R,G,B taken from rom_data:
  - RGB: output = rom_data.
  - Grey: Y = (77R + 150G + 29B) >> 8, computed at COLOR_DEPTH+8 bits, truncated, output {Y,Y,Y}.
  - Threshold: Y ≥ thresh_s gives all-ones, otherwise all-zeros.
  - Invert: bitwise NOT of rom_data.
- Delayed hit=0: rgb_out = delayed rgb_in.
- en_s=0: pure pass-through, with the same latency.

## Timing
- Total latency L = RD_LAT + 2 clocks from a vs_in/hs_in/de_in/rgb_in sample to the matching output:
  - 1 clock for the address/hit register.
  - RD_LAT clocks for the ROM.
  - 1 clock for the merge register.
- Syncs, de and rgb_in are carried in a shift register L deep (rgb_in needs L−1 stages before the merge). hit and mode_s are delayed alongside.
- Reset (rst_n=0, asynchronous): all counters, shadow registers, pipeline stages and outputs go to 0. This gives rom_addr=0, rgb_out=0, vs_out=hs_out=de_out=0, and shadow en_s=0. After release, the overlay stays disabled until the first frame start.
- Reset mid-frame: outputs are 0 immediately. Normal output resumes after the next vs_in rise plus L clocks, with no partial window.
- Boundaries:
  - vs_in rising on the same clock as de_in: frame-start clearing wins for y_cnt and row_base; x_cnt still counts.
  - Window overlapping the right or bottom edge: pixels off screen are simply never fetched, and row_base still advances per visible line.
  - pos_x_s ≥ active width: no hit for the whole frame.

## Test plan
- Reset/pass-through: rst_n low mid-line; all outputs are 0 within the same clock. Then en=0 with a 64-pixel ramp on rgb_in gives rgb_out equal to the ramp delayed RD_LAT+2, and syncs are aligned.
- RGB window: IMG_W=IMG_H=4, pos=(2,1), ROM[a]=a. Line 1, x=2..5 gives rom_addr 0,1,2,3 and rgb_out 0..3 at latency L. Line 4, x=2 gives addr 12. Other pixels give rgb_in.
- Grey: ROM word {R,G,B}={0xFF,0x00,0x00} gives {0x4C,0x4C,0x4C}. {0xFF,0xFF,0xFF} gives 0xFF per channel.
- Threshold/invert: thresh=0x80. Y=0x80 gives 0xFFFFFF; Y=0x7F gives 0x000000. Invert mode with 0x123456 gives 0xEDCBA9.
- Clipping: pos_x = active width − 2. Only 2 pixels per line are fetched (addr 0,1, then IMG_W, IMG_W+1). The next line's row_base increments correctly.
- Frame-latched controls: change mode and pos_x mid-frame; output is unchanged until after the next vs_in rise. Sweep RD_LAT=1 and 2, and check latency is 3 and 4.
